floating_point_accumulator: RTL



---
 rtl/floating_point_accumulator_pkg.sv | 20 ++
 rtl/floating_point_accumulator_adder.sv | 124 ++++++++++++
 rtl/floating_point_accumulator.sv | 93 +++++++++
 3 files changed

// File: rtl/floating_point_accumulator_pkg.sv
// Shared types for the floating-point accumulator: FSM encoding and the
// exception-flag bundle produced by the adder and held sticky by the top.
package floating_point_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_t;

  typedef struct packed {
    logic underflow;
    logic overflow;
    logic invalid;
  } fp_flags_t;

  // Guard, round and sticky bits carried below the significand while adding.
  localparam int GUARD_BITS = 3;

endpackage

// File: rtl/floating_point_accumulator_adder.sv
// Combinational IEEE-754 style adder/subtractor with round-to-nearest-even,
// subnormal support, Inf/NaN handling and underflow/overflow/invalid flags.
module floating_point_adder
  import floating_point_accumulator_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  localparam int FW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  input  logic          subtract,
  output logic [FW-1:0] sum,
  output fp_flags_t     flags
);

  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = M + 1 + GUARD_BITS;
  localparam int XW = E + 2;
  localparam logic [E-1:0]  EXP_MAX = '1;
  localparam logic [FW-1:0] QNAN    = {1'b1, EXP_MAX, 1'b1, {(M-1){1'b0}}};

  logic          sign_a, sign_b;
  logic [E-1:0]  exp_a, exp_b;
  logic [M-1:0]  man_a, man_b;
  logic          nan_a, nan_b, inf_a, inf_b, a_is_big;
  logic          big_sign, same_sign;
  logic [E-1:0]  big_exp, small_exp, diff;
  logic [W-1:0]  big_sig, small_sig, shifted, norm;
  logic [W:0]    raw;
  logic [XW-1:0] exp_n, exp_f;
  logic [M+1:0]  rounded;
  logic [M-1:0]  man_f;
  logic          round_up, res_sign;
  int            lz, shift;

  assign sign_a   = a[FW-1];
  assign sign_b   = b[FW-1] ^ subtract;
  assign exp_a    = a[FW-2:M];
  assign exp_b    = b[FW-2:M];
  assign man_a    = a[M-1:0];
  assign man_b    = b[M-1:0];
  assign nan_a    = (exp_a == EXP_MAX) && (man_a != '0);
  assign nan_b    = (exp_b == EXP_MAX) && (man_b != '0);
  assign inf_a    = (exp_a == EXP_MAX) && (man_a == '0);
  assign inf_b    = (exp_b == EXP_MAX) && (man_b == '0);
  assign a_is_big = a[FW-2:0] >= b[FW-2:0];

  // Align, add magnitudes, normalise, round, then override for special operands.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves a value held (which would infer a latch).
    flags     = '0;
    same_sign = (sign_a == sign_b);
    big_sign  = a_is_big ? sign_a : sign_b;
    // Subnormals use exponent 1 with a zero hidden bit.
    big_exp   = a_is_big ? ((exp_a == '0) ? E'(1) : exp_a) : ((exp_b == '0) ? E'(1) : exp_b);
    small_exp = a_is_big ? ((exp_b == '0) ? E'(1) : exp_b) : ((exp_a == '0) ? E'(1) : exp_a);
    big_sig   = a_is_big ? {exp_a != '0, man_a, {GUARD_BITS{1'b0}}}
                         : {exp_b != '0, man_b, {GUARD_BITS{1'b0}}};
    small_sig = a_is_big ? {exp_b != '0, man_b, {GUARD_BITS{1'b0}}}
                         : {exp_a != '0, man_a, {GUARD_BITS{1'b0}}};
    diff      = big_exp - small_exp;

    // Bits shifted out of the smaller operand collapse into the sticky LSB.
    if (int'(diff) >= W)
      shifted = {{(W-1){1'b0}}, |small_sig};
    else
      shifted = (small_sig >> diff) | {{(W-1){1'b0}}, |(small_sig & ~({W{1'b1}} << diff))};

    raw = same_sign ? ({1'b0, big_sig} + {1'b0, shifted})
                    : ({1'b0, big_sig} - {1'b0, shifted});

    lz = W;
    for (int i = 0; i < W; i++)
      if (raw[i]) lz = W - 1 - i;

    // Left shift stops at exponent 1 so tiny results become subnormal.
    shift = (lz < int'(big_exp) - 1) ? lz : int'(big_exp) - 1;
    if (raw[W]) begin
      norm  = raw[W:1] | {{(W-1){1'b0}}, raw[0]};
      exp_n = {2'b00, big_exp} + XW'(1);
    end else begin
      norm  = raw[W-1:0] << shift;
      exp_n = {2'b00, big_exp} - XW'(shift);
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[W-1:GUARD_BITS]} + {{(M+1){1'b0}}, round_up};
    if (rounded[M+1]) begin
      exp_f = exp_n + XW'(1);
      man_f = '0;
    end else if (!rounded[M]) begin
      exp_f = '0;
      man_f = rounded[M-1:0];
    end else begin
      exp_f = exp_n;
      man_f = rounded[M-1:0];
    end

    // An exact cancellation of opposite signs gives +0.
    res_sign = (raw == '0 && !same_sign) ? 1'b0 : big_sign;
    sum      = {res_sign, exp_f[E-1:0], man_f};

    if (exp_f >= {2'b00, EXP_MAX}) begin
      sum            = {res_sign, EXP_MAX, {M{1'b0}}};
      flags.overflow = 1'b1;
    end
    if (exp_f == '0 && norm[2:0] != '0)
      flags.underflow = 1'b1;

    if (nan_a || nan_b || (inf_a && inf_b && !same_sign)) begin
      sum   = QNAN;
      flags = '{underflow: 1'b0, overflow: inf_a | inf_b, invalid: 1'b1};
    end else if (inf_a) begin
      sum   = {sign_a, EXP_MAX, {M{1'b0}}};
      flags = '{underflow: 1'b0, overflow: 1'b1, invalid: 1'b0};
    end else if (inf_b) begin
      sum   = {sign_b, EXP_MAX, {M{1'b0}}};
      flags = '{underflow: 1'b0, overflow: 1'b1, invalid: 1'b0};
    end
  end

endmodule

// File: rtl/floating_point_accumulator.sv
// Burst accumulator: sums a valid/ready stream of floats through one adder and
// presents sum, beat count and sticky flags once the last beat is accepted.
module floating_point_accumulator
  import floating_point_accumulator_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int COUNT_WIDTH    = 16,
  localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLOAT_BIT_WIDTH-1:0] in_data,
  input  logic                       in_subtract,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLOAT_BIT_WIDTH-1:0] out_data,
  output logic [COUNT_WIDTH-1:0]     out_count,
  output logic                       underflow_flag,
  output logic                       overflow_flag,
  output logic                       invalid_operation_flag
);

  acc_state_t                 state_q, state_d;
  logic [FLOAT_BIT_WIDTH-1:0] acc_q, sum;
  logic [COUNT_WIDTH-1:0]     count_q;
  fp_flags_t                  flags_q, beat_flags;
  logic                       accept, out_fire;

  floating_point_adder #(
    .EXPONENT_WIDTH (EXPONENT_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_adder (
    .a        (acc_q),
    .b        (in_data),
    .subtract (in_subtract),
    .sum      (sum),
    .flags    (beat_flags)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a last beat closes the burst, the output handshake reopens it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: if (accept) state_d = in_last ? ST_HOLD : ST_ACCUM;
      ST_HOLD:           if (out_fire) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q != ST_HOLD);
    out_valid = (state_q == ST_HOLD);
    accept    = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Accumulator, saturating beat counter and sticky flags; cleared on output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain registers (no memory arrays), so all of them take the async reset.
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      flags_q <= '0;
    end else if (out_fire) begin
      acc_q   <= '0;
      count_q <= '0;
      flags_q <= '0;
    end else if (accept) begin
      acc_q   <= sum;
      flags_q <= flags_q | beat_flags;
      if (count_q != '1) count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign out_data               = acc_q;
  assign out_count              = count_q;
  assign underflow_flag         = flags_q.underflow;
  assign overflow_flag          = flags_q.overflow;
  assign invalid_operation_flag = flags_q.invalid;

endmodule
